// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM encoding, special instruction encodings
// and the bit positions of the instruction fields.
package fetch_stage_pkg;

  localparam int unsigned XLEN     = 16;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned IMM_W    = 8;
  localparam int unsigned ADDR_W   = 11;

  localparam int unsigned OPC_LSB  = 11;
  localparam int unsigned REG1_LSB = 8;
  localparam int unsigned REG2_LSB = 5;
  localparam int unsigned REG3_LSB = 2;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned ADDR_LSB = 0;

  localparam logic [XLEN-1:0]  RESET_PC    = 16'h0000;
  localparam logic [XLEN-1:0]  PC_STEP     = 16'h0002;
  localparam logic [OPC_W-1:0] HALT_OPCODE = 5'b00000;
  localparam logic [XLEN-1:0]  NOP_INSTR   = 16'h0800;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  reg3;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] address;
  } instr_fields_t;

endpackage

// File: rtl/fetch_stage_instr_fields.sv
// Combinational slicer of an instruction word into the fields decode consumes.
module fetch_stage_instr_fields
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output instr_fields_t   fields_o
);

  always_comb begin
    fields_o.opcode  = instr_i[OPC_LSB  +: OPC_W];
    fields_o.reg1    = instr_i[REG1_LSB +: REG_W];
    fields_o.reg2    = instr_i[REG2_LSB +: REG_W];
    fields_o.reg3    = instr_i[REG3_LSB +: REG_W];
    fields_o.imm     = instr_i[IMM_LSB  +: IMM_W];
    fields_o.address = instr_i[ADDR_LSB +: ADDR_W];
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, variable-latency memory requests, a one-deep
// instruction holding register toward decode, redirects and HALT.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  output logic              MemRd,
  output logic [XLEN-1:0]   MemAddr,
  input  logic [XLEN-1:0]   MemData,
  input  logic              MemReady,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [XLEN-1:0]   RedirectPC,
  output logic [XLEN-1:0]   Instr,
  output logic              InstrValid,
  output logic [XLEN-1:0]   PCPlus2,
  output logic [REG_W-1:0]  Reg1,
  output logic [REG_W-1:0]  Reg2,
  output logic [REG_W-1:0]  Reg3,
  output logic [IMM_W-1:0]  Imm,
  output logic [ADDR_W-1:0] Address,
  output logic              Halted
);

  localparam logic [XLEN-1:0] RESET_PCP2 = RESET_PC + PC_STEP;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcp2_q, pcp2_d;

  instr_fields_t   fields;
  logic            halt_held;
  logic            fetch_req;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redirect_pc;

  fetch_stage_instr_fields u_fields (
    .instr_i  (instr_q),
    .fields_o (fields)
  );

  assign halt_held   = (fields.opcode == HALT_OPCODE);
  assign pc_next     = pc_q + PC_STEP;
  assign redirect_pc = {RedirectPC[XLEN-1:1], 1'b0};

  // A request goes out while empty, or as a prefetch when decode takes a non-HALT word.
  assign fetch_req = !Redirect &&
                     ((state_q == ST_FETCH) ||
                      ((state_q == ST_HOLD) && !Stall && !halt_held));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp2_q  <= RESET_PCP2;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp2_d  = pcp2_q;
    case (state_q)
      ST_FETCH, ST_HOLD: begin
        if (Redirect) begin
          // Squash whatever is held or returning this cycle.
          state_d = ST_FETCH;
          pc_d    = redirect_pc;
          instr_d = NOP_INSTR;
        end else if (fetch_req) begin
          if (MemReady) begin
            state_d = ST_HOLD;
            instr_d = MemData;
            pc_d    = pc_next;
            pcp2_d  = pc_next;
          end else begin
            state_d = ST_FETCH;
          end
        end else if ((state_q == ST_HOLD) && !Stall) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    MemRd      = fetch_req;
    MemAddr    = pc_q;
    InstrValid = (state_q == ST_HOLD);
    Halted     = (state_q == ST_HALT);
  end

  assign Instr   = instr_q;
  assign PCPlus2 = pcp2_q;
  assign Reg1    = fields.reg1;
  assign Reg2    = fields.reg2;
  assign Reg3    = fields.reg3;
  assign Imm     = fields.imm;
  assign Address = fields.address;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait and delayed memory, stall, redirect,
// HALT handling, PC wrap and asynchronous reset mid-request.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRd;
  logic [15:0] MemAddr;
  logic [15:0] MemData;
  logic        MemReady;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic [15:0] Instr;
  logic        InstrValid;
  logic [15:0] PCPlus2;
  logic [2:0]  Reg1, Reg2, Reg3;
  logic [7:0]  Imm;
  logic [10:0] Address;
  logic        Halted;

  logic        mem_auto;
  logic        ready_drv;
  logic [15:0] data_drv;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 Clk = ~Clk;

  // Zero-wait memory returns 16'h4000+addr; otherwise the bench drives it directly.
  assign MemReady = mem_auto ? MemRd : ready_drv;
  assign MemData  = mem_auto ? (MemAddr + 16'h4000) : data_drv;

  fetch_stage dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .MemRd      (MemRd),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .MemReady   (MemReady),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PCPlus2    (PCPlus2),
    .Reg1       (Reg1),
    .Reg2       (Reg2),
    .Reg3       (Reg3),
    .Imm        (Imm),
    .Address    (Address),
    .Halted     (Halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;
    mem_auto = 1'b1; ready_drv = 1'b0; data_drv = 16'h0000;

    // Reset values
    repeat (2) @(posedge Clk);
    #1;
    chk ("rst_instr", Instr, 16'h0800);
    chk1("rst_valid", InstrValid, 1'b0);
    chk ("rst_pcp2", PCPlus2, 16'h0002);
    chk1("rst_halted", Halted, 1'b0);
    chk ("rst_imm", 16'(Imm), 16'h0000);
    chk ("rst_address", 16'(Address), 16'h0000);

    // Zero-wait memory, one instruction per cycle
    Rst = 1'b1;
    #1;
    chk1("c0_memrd", MemRd, 1'b1);
    chk ("c0_memaddr", MemAddr, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk ("zw_instr", Instr, 16'h4000 + 16'(2 * (k - 1)));
      chk1("zw_valid", InstrValid, 1'b1);
      chk ("zw_pcp2", PCPlus2, 16'(2 * k));
      chk ("zw_memaddr", MemAddr, 16'(2 * k));
      chk1("zw_memrd", MemRd, 1'b1);
    end

    // 3-cycle memory latency on the request to 16'h000A
    mem_auto = 1'b0; ready_drv = 1'b0; data_drv = 16'h6A5C;
    #1;
    chk1("dl_req_rd", MemRd, 1'b1);
    chk ("dl_req_addr", MemAddr, 16'h000A);
    tick();
    chk1("dl_w1_valid", InstrValid, 1'b0);
    chk ("dl_w1_addr", MemAddr, 16'h000A);
    chk1("dl_w1_rd", MemRd, 1'b1);
    tick();
    chk1("dl_w2_valid", InstrValid, 1'b0);
    chk ("dl_w2_addr", MemAddr, 16'h000A);
    tick();
    chk1("dl_w3_valid", InstrValid, 1'b0);
    ready_drv = 1'b1; Stall = 1'b1;
    #1;
    chk1("dl_w3_rd", MemRd, 1'b1);
    tick();
    ready_drv = 1'b0;
    chk1("dl_valid", InstrValid, 1'b1);
    chk ("dl_instr", Instr, 16'h6A5C);
    chk ("dl_pcp2", PCPlus2, 16'h000C);

    // Stall for 4 cycles holding 16'h6A5C
    for (int i = 0; i < 4; i++) begin
      chk ("st_instr", Instr, 16'h6A5C);
      chk ("st_reg1", 16'(Reg1), 16'h0002);
      chk ("st_reg2", 16'(Reg2), 16'h0002);
      chk ("st_reg3", 16'(Reg3), 16'h0007);
      chk ("st_imm", 16'(Imm), 16'h005C);
      chk ("st_address", 16'(Address), 16'h025C);
      chk1("st_memrd", MemRd, 1'b0);
      chk1("st_valid", InstrValid, 1'b1);
      chk ("st_pcp2", PCPlus2, 16'h000C);
      tick();
    end
    Stall = 1'b0; mem_auto = 1'b1;
    #1;
    chk1("st_resume_rd", MemRd, 1'b1);
    chk ("st_resume_addr", MemAddr, 16'h000C);
    tick();
    chk ("st_next_instr", Instr, 16'h400C);
    chk ("st_next_pcp2", PCPlus2, 16'h000E);

    // Redirect coinciding with MemReady
    Redirect = 1'b1; RedirectPC = 16'h0123; mem_auto = 1'b0; ready_drv = 1'b1; data_drv = 16'h1234;
    #1;
    chk1("rd_memrd_low", MemRd, 1'b0);
    tick();
    Redirect = 1'b0; ready_drv = 1'b0;
    #1;
    chk ("rd_instr_nop", Instr, 16'h0800);
    chk1("rd_valid", InstrValid, 1'b0);
    chk ("rd_memaddr", MemAddr, 16'h0122);
    chk1("rd_memrd", MemRd, 1'b1);
    mem_auto = 1'b1;
    tick();
    chk ("rd_instr", Instr, 16'h4122);
    chk ("rd_pcp2", PCPlus2, 16'h0124);

    // HALT held, then squashed by a redirect
    mem_auto = 1'b0; ready_drv = 1'b1; data_drv = 16'h0000;
    tick();
    ready_drv = 1'b0; Stall = 1'b1;
    #1;
    chk ("h1_instr", Instr, 16'h0000);
    chk1("h1_valid", InstrValid, 1'b1);
    chk1("h1_halted", Halted, 1'b0);
    chk1("h1_memrd", MemRd, 1'b0);
    Redirect = 1'b1; RedirectPC = 16'h0200;
    tick();
    Redirect = 1'b0;
    #1;
    chk ("h1_squash_instr", Instr, 16'h0800);
    chk1("h1_squash_valid", InstrValid, 1'b0);
    chk1("h1_squash_halted", Halted, 1'b0);
    chk ("h1_refetch_addr", MemAddr, 16'h0200);
    chk1("h1_refetch_rd", MemRd, 1'b1);

    // HALT consumed once decode accepts
    ready_drv = 1'b1; data_drv = 16'h0000;
    tick();
    ready_drv = 1'b0;
    #1;
    chk1("h2_stall_rd", MemRd, 1'b0);
    Stall = 1'b0;
    #1;
    chk1("h2_no_prefetch", MemRd, 1'b0);
    chk1("h2_valid", InstrValid, 1'b1);
    tick();
    chk1("h2_halted", Halted, 1'b1);
    chk1("h2_valid_low", InstrValid, 1'b0);
    chk1("h2_memrd", MemRd, 1'b0);
    Redirect = 1'b1; RedirectPC = 16'h0300; mem_auto = 1'b1;
    #1;
    chk1("h2_redir_rd", MemRd, 1'b0);
    tick();
    Redirect = 1'b0;
    chk1("h2_redir_halted", Halted, 1'b1);
    chk ("h2_redir_instr", Instr, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("h2_stay_halted", Halted, 1'b1);
      chk1("h2_stay_rd", MemRd, 1'b0);
    end

    // Reset leaves HALT; PC wrap at 16'hFFFE, then reset mid-wait
    Rst = 1'b0;
    #1;
    chk1("r2_halted", Halted, 1'b0);
    chk ("r2_instr", Instr, 16'h0800);
    chk ("r2_pcp2", PCPlus2, 16'h0002);
    chk1("r2_valid", InstrValid, 1'b0);
    Rst = 1'b1; mem_auto = 1'b0; ready_drv = 1'b0; Redirect = 1'b1; RedirectPC = 16'hFFFF;
    #1;
    chk1("w_redir_rd", MemRd, 1'b0);
    tick();
    Redirect = 1'b0;
    #1;
    chk ("w_memaddr", MemAddr, 16'hFFFE);
    chk1("w_memrd", MemRd, 1'b1);
    ready_drv = 1'b1; data_drv = 16'h1357;
    tick();
    ready_drv = 1'b0;
    chk ("w_instr", Instr, 16'h1357);
    chk ("w_pcp2", PCPlus2, 16'h0000);
    chk1("w_valid", InstrValid, 1'b1);
    #1;
    chk1("w_prefetch_rd", MemRd, 1'b1);
    chk ("w_prefetch_addr", MemAddr, 16'h0000);
    tick();
    chk1("w_wait_valid", InstrValid, 1'b0);
    chk ("w_wait_pcp2", PCPlus2, 16'h0000);
    tick();
    Rst = 1'b0;
    #1;
    chk ("w_rst_pcp2", PCPlus2, 16'h0002);
    chk ("w_rst_instr", Instr, 16'h0800);
    chk1("w_rst_valid", InstrValid, 1'b0);
    chk1("w_rst_halted", Halted, 1'b0);
    chk ("w_rst_addr", MemAddr, 16'h0000);
    Rst = 1'b1; mem_auto = 1'b1;
    #1;
    chk1("w_restart_rd", MemRd, 1'b1);
    tick();
    chk ("w_restart_instr", Instr, 16'h4000);
    chk ("w_restart_pcp2", PCPlus2, 16'h0002);
    chk1("w_restart_valid", InstrValid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that feeds the decode stage: keeps the PC, issues read requests to a variable-latency instruction memory and holds the returned instruction until decode accepts it. It slices the instruction into the register selects, immediate and displacement fields decode consumes, and handles redirects from branch/jump resolution and the HALT instruction. It sits between instruction memory and decode, upstream of the register-file read ports.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset
- HALT_OPCODE, 5'b00000, opcode that stops fetching
- NOP_INSTR, 16'h0800, instruction register contents after reset and after a squash

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- MemRd  out  1  read request to instruction memory
- MemAddr  out  16  request address, valid while MemRd=1
- MemData  in  16  instruction word, valid when MemReady=1
- MemReady  in  1  memory completes the current request this cycle
- Stall  in  1  decode cannot accept the held instruction this cycle
- Redirect  in  1  squash and refetch from RedirectPC
- RedirectPC  in  16  new fetch address, bit 0 ignored (forced 0)
- Instr  out  16  held instruction
- InstrValid  out  1  Instr is valid for decode
- PCPlus2  out  16  address of held instruction + 2, mod 2^16
- Reg1  out  3  Instr[10:8]
- Reg2  out  3  Instr[7:5]
- Reg3  out  3  Instr[4:2]
- Imm  out  8  Instr[7:0]
- Address  out  11  Instr[10:0]
- Halted  out  1  HALT consumed, fetching stopped

## Operation
- States: FETCH, HOLD, HALT. Reset: state=FETCH, PC=RESET_PC, Instr=NOP_INSTR, InstrValid=0, PCPlus2=RESET_PC+2, Halted=0.
- FETCH: MemRd=1, MemAddr=PC. On MemReady: Instr<=MemData, PCPlus2<=PC+2, PC<=PC+2, go HOLD.
- HOLD: InstrValid=1. Accept = !Stall. On accept with non-HALT opcode: MemRd=1 (combinational on Stall), MemAddr=PC; if MemReady same cycle capture next instruction and stay HOLD (one instruction/cycle), else go FETCH with InstrValid=0.
- HOLD with opcode Instr[15:11]=HALT_OPCODE: no prefetch, MemRd=0; on accept go HALT.
- HALT: MemRd=0, InstrValid=0, Halted=1; exits only via Rst.
- Redirect (FETCH or HOLD): highest priority. PC<=RedirectPC, Instr<=NOP_INSTR, InstrValid<=0, go FETCH. Any MemData/MemReady in that cycle discarded; held instruction (including HALT) squashed. Redirect ignored in HALT.
- MemRd never high in the cycle Redirect is high.
- PC arithmetic 16-bit, wraps 16'hFFFE -> 16'h0000.
- Field outputs are pure slices of Instr; they track Instr including NOP_INSTR.

## Timing
- Zero-wait memory (MemReady same cycle as MemRd): first InstrValid one cycle after reset release; steady state one instruction per cycle while Stall=0.
- N-wait memory: InstrValid rises the cycle after MemReady.
- Redirect in cycle t: MemRd=1 with MemAddr=RedirectPC in t+1.
- Stall=1 holds Instr, PCPlus2, InstrValid unchanged; no new request.
- Rst assertion mid-request: state cleared immediately; outstanding memory request abandoned; memory must tolerate MemRd dropping before MemReady.

## Structure
- Shared package: state encoding (FETCH/HOLD/HALT), HALT opcode, NOP encoding, instruction field bit positions — shared with decode.
- One sub-module natural: instr_fields, combinational slicer of Instr into Reg1/Reg2/Reg3/Imm/Address, reused by decode's testbench.

## Test plan
- Reset, zero-wait memory returning 16'h4000+addr, Stall=0 -> MemAddr 0,2,4,... one per cycle; InstrValid high from cycle 1; PCPlus2 matches.
- MemReady delayed 3 cycles each request -> InstrValid low 3 cycles, rises cycle after MemReady; MemAddr stable while waiting.
- Stall=1 for 4 cycles while holding 16'h6A5C -> Instr, Reg1=3'd2, Reg2=3'd2, Reg3=3'd7, Imm=8'h5C unchanged; MemRd=0; resumes on Stall=0.
- Redirect to 16'h0123 in same cycle as MemReady -> data discarded, next MemAddr=16'h0122, Instr=16'h0800, InstrValid=0.
- Instruction 16'h0000 returned -> held until Stall=0, then Halted=1, MemRd=0 permanently; Redirect ignored; HALT squashed if Redirect arrives while held.
- PC at 16'hFFFE, Rst pulsed low mid-wait -> PCPlus2 wraps to 16'h0000; Rst restarts fetch at RESET_PC with all outputs at reset values.
